// File: rtl/dlfloat_dot_engine.sv
// dlfloat_dot_engine: DLFloat16 multiply-accumulate dot product over VEC_LEN pairs, word or byte-serial result.
// Define DLFLOAT_SAT_EN to saturate/flush out-of-range exponents; otherwise they wrap modulo 64.
module dlfloat_dot_engine #(
  parameter int VEC_LEN = 4,
  parameter int OUT_SERIAL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);
  localparam int CW = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);
  typedef enum logic [1:0] {ACC, DRAIN, HOLD_HI, HOLD_LO} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] prod_q, prod_d, acc_q, acc_d;
  logic hs, hold;

  function automatic logic [15:0] pack(input logic s, input logic signed [8:0] e, input logic [8:0] m);
`ifdef DLFLOAT_SAT_EN
    pack = e > 9'sd63 ? {s, 6'h3F, 9'h1FE} : e < 9'sd1 ? 16'h0000 : {s, 6'(e), m};
`else
    pack = {s, 6'(e), m};
`endif
  endfunction

  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic [10:0] pt;
    logic signed [8:0] e;
    pt = 11'((20'({1'b1, a[8:0]}) * 20'({1'b1, b[8:0]})) >> 9);
    e = $signed(9'(a[14:9]) + 9'(b[14:9]) + 9'(pt[10]) - 9'd31);
    fmul = (a == 16'hFFFF || b == 16'hFFFF) ? 16'hFFFF :
           (a == 16'h0000 || b == 16'h0000) ? 16'h0000 :
           pack(a[15] ^ b[15], e, pt[10] ? pt[9:1] : pt[8:0]);
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] l, s;
    logic [5:0] d;
    logic [10:0] ml, ms, r;
    logic [3:0] sh;
    logic signed [8:0] e;
    l = x[14:0] >= y[14:0] ? x : y;
    s = x[14:0] >= y[14:0] ? y : x;
    d = l[14:9] - s[14:9];
    ml = {2'b01, l[8:0]};
    ms = {2'b01, s[8:0]} >> d;
    r = l[15] == s[15] ? ml + ms : ml - ms;
    sh = 4'd0;
    // leading-one search; the highest set bit wins
    for (int i = 0; i < 10; i++) if (r[i]) sh = 4'(9 - i);
    sh = r[10] ? 4'd0 : sh;
    e = $signed(9'(l[14:9]) + 9'(r[10]) - 9'(sh));
    fadd = (x == 16'hFFFF || y == 16'hFFFF) ? 16'hFFFF :
           x == 16'h0000 ? y :
           y == 16'h0000 ? x :
           r == 11'd0 ? 16'h0000 :
           pack(l[15], e, r[10] ? r[9:1] : 9'(r << sh));
  endfunction

  assign hold = state_q == HOLD_HI || state_q == HOLD_LO;
  assign in_ready = state_q == ACC;
  assign hs = in_valid && in_ready && !clear;
  assign out_valid = hold;
  assign busy = cnt_q != '0 || state_q != ACC;
  assign out_data = !hold ? 16'h0000 : OUT_SERIAL == 0 ? acc_q :
                    {8'h00, state_q == HOLD_HI ? acc_q[15:8] : acc_q[7:0]};

  // idle cycles load a zero product, which leaves the accumulator untouched
  always_comb begin
    state_d = state_q;
    cnt_d = hs ? (cnt_q == LAST ? '0 : cnt_q + CW'(1)) : cnt_q;
    prod_d = hs ? fmul(in_a, in_b) : 16'h0000;
    acc_d = fadd(acc_q, prod_q);
    if (hs && cnt_q == LAST) state_d = DRAIN;
    if (state_q == DRAIN) state_d = HOLD_HI;
    if (out_ready && state_q == HOLD_HI) state_d = OUT_SERIAL != 0 ? HOLD_LO : ACC;
    if (out_ready && state_q == HOLD_LO) state_d = ACC;
    if ((hold && state_d == ACC) || (clear && !hold)) begin
      state_d = ACC;
      cnt_d = '0;
      prod_d = 16'h0000;
      acc_d = 16'h0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q <= '0;
      prod_q <= 16'h0000;
      acc_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      prod_q <= prod_d;
      acc_q <= acc_d;
    end
endmodule

// File: tb/tb_dlfloat_dot_engine.sv
// tb_dlfloat_dot_engine: four engine configurations (VEC_LEN 4/2/1 word, VEC_LEN 4 serial) against a value-level model.
module tb_dlfloat_dot_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear [4];
  logic in_valid [4];
  logic in_ready [4];
  logic out_valid [4];
  logic out_ready [4];
  logic busy [4];
  logic [15:0] in_a [4];
  logic [15:0] in_b [4];
  logic [15:0] out_data [4];
  logic [15:0] qa [$];
  logic [15:0] qb [$];
  int checks = 0;
  int failures = 0;
`ifdef DLFLOAT_SAT_EN
  localparam logic [15:0] OVF = 16'h7FFE;
`else
  localparam logic [15:0] OVF = 16'h0000;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dlfloat_dot_engine #(.VEC_LEN(g == 2 ? 1 : g == 1 ? 2 : 4), .OUT_SERIAL(g == 3 ? 1 : 0)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_data(out_data[g]), .busy(busy[g]));
  end

  function automatic int vlen(input int k);
    return k == 2 ? 1 : k == 1 ? 2 : 4;
  endfunction

  function automatic logic [15:0] m_pack(input bit s, input int e, input int m);
`ifdef DLFLOAT_SAT_EN
    if (e > 63) return {s, 6'h3F, 9'h1FE};
    if (e < 1) return 16'h0000;
`endif
    return {s, 6'(e & 63), 9'(m)};
  endfunction

  // value = (-1)^s * 2^(e-31) * M/512 with M = 512 + mantissa
  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    int p, e;
    if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
    if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
    p = (512 + int'(a[8:0])) * (512 + int'(b[8:0]));
    e = int'(a[14:9]) + int'(b[14:9]) - 31;
    if (p >= (1 << 19)) begin p = p / 2; e++; end
    return m_pack(a[15] ^ b[15], e, (p / 512) % 512);
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] big, sml;
    int mb, ms, e, r;
    if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
    if (x == 16'h0000) return y;
    if (y == 16'h0000) return x;
    big = int'(x[14:0]) >= int'(y[14:0]) ? x : y;
    sml = big == x ? y : x;
    mb = 512 + int'(big[8:0]);
    ms = (512 + int'(sml[8:0])) >> (int'(big[14:9]) - int'(sml[14:9]));
    r = big[15] == sml[15] ? mb + ms : mb - ms;
    if (r == 0) return 16'h0000;
    e = int'(big[14:9]);
    while (r >= 1024) begin r = r / 2; e++; end
    while (r < 512) begin r = r * 2; e--; end
    return m_pack(big[15], e, r % 512);
  endfunction

  function automatic logic [15:0] vec_model();
    logic [15:0] acc = 16'h0000;
    foreach (qa[i]) acc = m_add(acc, m_mul(qa[i], qb[i]));
    return acc;
  endfunction

  function automatic logic [15:0] rnd_op();
    int r = $urandom_range(49, 0);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'hFFFF;
    if (r < 6) return 16'($urandom);
    return {1'($urandom_range(1, 0)), 6'($urandom_range(35, 27)), 9'($urandom)};
  endfunction

  task automatic fill(input int n);
    qa.delete();
    qb.delete();
    repeat (n) begin
      qa.push_back(rnd_op());
      qb.push_back(rnd_op());
    end
  endtask

  task automatic feed(input int k);
    foreach (qa[i]) begin
      in_valid[k] = 1'b1;
      in_a[k] = qa[i];
      in_b[k] = qb[i];
      @(negedge clk);
    end
    in_valid[k] = 1'b0;
  endtask

  // observes one result starting one edge after the last handshake: {valid@1, valid@2, held-ok, word}
  task automatic collect(input int k, output logic [18:0] res);
    logic [15:0] hi, lo;
    logic early, v2, st;
    early = out_valid[k];
    @(negedge clk);
    v2 = out_valid[k];
    for (int t = 0; t < 8 && !out_valid[k]; t++) @(negedge clk);
    hi = out_data[k];
    st = out_valid[k];
    repeat (2) begin
      @(negedge clk);
      st &= out_valid[k] && !in_ready[k] && out_data[k] == hi;
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    lo = hi;
    if (k == 3) begin
      lo = out_data[k];
      st &= out_valid[k] && hi[15:8] == 8'h00 && lo[15:8] == 8'h00;
      repeat (2) begin
        @(negedge clk);
        st &= out_valid[k] && out_data[k] == lo;
      end
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
    end
    st &= !out_valid[k] && !busy[k];
    res = {early, v2, st, k == 3 ? {hi[7:0], lo[7:0]} : hi};
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({out_valid[k], busy[k], out_data[k]} !== 18'h0) begin
        failures++;
        $display("FAIL reset_outputs k=%0d got=%h required=00000", k, {out_valid[k], busy[k], out_data[k]});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1) begin
        failures++;
        $display("FAIL reset_in_ready k=%0d got=%b required=1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_directed;
    logic [18:0] got;
    logic [15:0] exp;
    int k;
    for (int t = 0; t < 6; t++) begin
      case (t)
        0: begin k = 0; qa = '{16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00}; qb = qa; exp = 16'h4200; end
        1: begin k = 1; qa = '{16'h4000, 16'h3E00}; qb = '{16'h3F00, 16'hBE00}; exp = 16'h4000; end
        2: begin k = 1; qa = '{16'h3E00, 16'hBE00}; qb = '{16'h3E00, 16'h3E00}; exp = 16'h0000; end
        3: begin k = 2; qa = '{16'h7E00}; qb = '{16'h4000}; exp = OVF; end
        4: begin k = 2; qa = '{16'hFFFF}; qb = '{16'h3E00}; exp = 16'hFFFF; end
        default: begin k = 3; qa = '{16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00}; qb = qa; exp = 16'h4200; end
      endcase
      feed(k);
      collect(k, got);
      checks++;
      if (got !== {3'b011, exp}) begin
        failures++;
        $display("FAIL directed t=%0d k=%0d got=%h required=%h", t, k, got, {3'b011, exp});
      end
    end
  endtask

  task automatic test_random;
    logic [18:0] got, exp;
    for (int k = 0; k < 4; k++) repeat (6) begin
      fill(vlen(k));
      exp = {3'b011, vec_model()};
      feed(k);
      collect(k, got);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random k=%0d got=%h required=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_stall;
    logic [18:0] got;
    logic [15:0] exp;
    fill(4);
    exp = vec_model();
    feed(0);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_a[0] = 16'h4000;
    in_b[0] = 16'h4000;
    repeat (5) begin
      checks++;
      if ({out_valid[0], in_ready[0], busy[0], out_data[0]} !== {3'b101, exp}) begin
        failures++;
        $display("FAIL stall_hold got=%h required=%h", {out_valid[0], in_ready[0], busy[0], out_data[0]}, {3'b101, exp});
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b0;
    fill(4);
    exp = vec_model();
    feed(0);
    collect(0, got);
    checks++;
    if (got !== {3'b011, exp}) begin
      failures++;
      $display("FAIL stall_next_vector got=%h required=%h", got, {3'b011, exp});
    end
  endtask

  task automatic test_clear;
    logic [18:0] got;
    logic [15:0] exp;
    logic seen;
    fill(2);
    feed(0);
    clear[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_a[0] = 16'h4000;
    in_b[0] = 16'h4000;
    @(negedge clk);
    clear[0] = 1'b0;
    in_valid[0] = 1'b0;
    checks++;
    if ({busy[0], out_valid[0]} !== 2'b00) begin
      failures++;
      $display("FAIL clear_acc got=%b required=00", {busy[0], out_valid[0]});
    end
    for (int t = 0; t < 2; t++) begin
      fill(4);
      exp = vec_model();
      feed(0);
      if (t == 1) begin
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0;
        seen = 1'b0;
        repeat (3) begin
          seen |= out_valid[0] | busy[0];
          @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
          failures++;
          $display("FAIL clear_drain got=%b required=0", seen);
        end
        fill(4);
        exp = vec_model();
        feed(0);
      end
      collect(0, got);
      checks++;
      if (got !== {3'b011, exp}) begin
        failures++;
        $display("FAIL clear_fresh t=%0d got=%h required=%h", t, got, {3'b011, exp});
      end
    end
  endtask

  task automatic test_reset_hold;
    logic [18:0] got;
    logic [15:0] exp;
    fill(4);
    feed(0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid[0], busy[0], out_data[0]} !== 18'h0) begin
      failures++;
      $display("FAIL reset_hold got=%h required=00000", {out_valid[0], busy[0], out_data[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(4);
    exp = vec_model();
    feed(0);
    collect(0, got);
    checks++;
    if (got !== {3'b011, exp}) begin
      failures++;
      $display("FAIL reset_fresh got=%h required=%h", got, {3'b011, exp});
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      clear[k] = 1'b0;
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      in_a[k] = 16'h0000;
      in_b[k] = 16'h0000;
    end
    test_reset;
    test_directed;
    test_random;
    test_stall;
    test_clear;
    test_reset_hold;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
